// File: rtl/z80_mem_bridge.sv
// Z80 bus to single-request memory/I/O bridge: one registered request per CPU
// bus cycle, wait-state generation, and a sticky timeout abort.
module z80_mem_bridge #(
  parameter logic [7:0]  IO_PAGE  = 8'h10,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  cpu_di_q, cpu_di_d;
  logic        cpu_wait_n_q, cpu_wait_n_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic start_mem, start_io;

  // Refresh and interrupt-acknowledge cycles are excluded by the rfsh/m1 terms.
  assign start_mem = ~cpu_mreq_n & cpu_rfsh_n & (~cpu_rd_n | ~cpu_wr_n);
  assign start_io  = ~cpu_iorq_n & cpu_m1_n   & (~cpu_rd_n | ~cpu_wr_n);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_di_d      = cpu_di_q;
    cpu_wait_n_d  = cpu_wait_n_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_mem || start_io) begin
          state_d      = ST_REQ;
          mem_req_d    = 1'b1;
          cpu_wait_n_d = 1'b0;
          mem_we_d     = ~cpu_wr_n;
          mem_wdata_d  = cpu_do;
          mem_addr_d   = start_mem ? cpu_a : {IO_PAGE, cpu_a[7:0]};
          wait_cnt_d   = '0;
        end
      end

      ST_REQ: begin
        // An ack on the limit edge wins over the timeout abort.
        if (mem_ack) begin
          state_d      = ST_HOLD;
          mem_req_d    = 1'b0;
          cpu_wait_n_d = 1'b1;
          if (!mem_we_q) cpu_di_d = mem_rdata;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d       = ST_HOLD;
          mem_req_d     = 1'b0;
          cpu_wait_n_d  = 1'b1;
          timeout_err_d = 1'b1;
          if (!mem_we_q) cpu_di_d = '1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (cpu_rd_n && cpu_wr_n) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_di_q      <= '0;
      cpu_wait_n_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_di_q      <= cpu_di_d;
      cpu_wait_n_q  <= cpu_wait_n_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign cpu_di      = cpu_di_q;
  assign cpu_wait_n  = cpu_wait_n_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed bench for z80_mem_bridge: inputs change on the falling edge,
// outputs are sampled on the falling edge after the active rising edge.
module tb_z80_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  z80_mem_bridge #(.IO_PAGE(8'h10), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n),
    .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n),
    .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic bus_idle();
    cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1;
    cpu_wr_n = 1'b1; cpu_m1_n = 1'b1; cpu_rfsh_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_idle(); mem_ack = 1'b0; mem_rdata = 8'h00;
    cpu_a = 16'h0000; cpu_do = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 00", mem_wdata); end
    checks++; if (cpu_di !== 8'h00) begin errors++; $display("FAIL rst_cpu_di: got %h expected 00", cpu_di); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rst_wait_n: got %b expected 1", cpu_wait_n); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b expected 0", timeout_err); end
    reset = 1'b0;
  endtask

  task automatic test_mem_read();
    int wait_low = 0;
    @(negedge clk);
    cpu_a = 16'hA811; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; mem_rdata = 8'h7E;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_mem_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 16'hA811) begin errors++; $display("FAIL rd_mem_addr: got %h expected a811", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
    if (!cpu_wait_n) wait_low++;
    @(negedge clk);
    if (!cpu_wait_n) wait_low++;
    mem_ack = 1'b1;
    @(negedge clk);
    if (!cpu_wait_n) wait_low++;
    checks++; if (wait_low != 2) begin errors++; $display("FAIL rd_wait_cycles: got %0d expected 2", wait_low); end
    checks++; if (cpu_di !== 8'h7E) begin errors++; $display("FAIL rd_cpu_di: got %h expected 7e", cpu_di); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b expected 0", mem_req); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_mem_write();
    int pulses = 0;
    logic prev = 1'b0;
    @(negedge clk);
    cpu_a = 16'h1234; cpu_do = 8'h5A; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_req && !prev) pulses++;
      if (i == 0) begin
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
        checks++; if (mem_wdata !== 8'h5A) begin errors++; $display("FAIL wr_mem_wdata: got %h expected 5a", mem_wdata); end
        checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL wr_mem_addr: got %h expected 1234", mem_addr); end
      end
      prev = mem_req;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wr_req_pulses: got %0d expected 1", pulses); end
    checks++; if (cpu_di !== 8'h7E) begin errors++; $display("FAIL wr_cpu_di_hold: got %h expected 7e", cpu_di); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_io_read();
    @(negedge clk);
    cpu_a = 16'hFF3C; cpu_iorq_n = 1'b0; cpu_m1_n = 1'b1; cpu_rd_n = 1'b0; mem_rdata = 8'hC3;
    @(negedge clk);
    checks++; if (mem_addr !== 16'h103C) begin errors++; $display("FAIL io_mem_addr: got %h expected 103c", mem_addr); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL io_mem_req: got %b expected 1", mem_req); end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (cpu_di !== 8'hC3) begin errors++; $display("FAIL io_cpu_di: got %h expected c3", cpu_di); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_priority();
    @(negedge clk);
    cpu_a = 16'h12AB; cpu_mreq_n = 1'b0; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0; mem_rdata = 8'h21;
    @(negedge clk);
    checks++; if (mem_addr !== 16'h12AB) begin errors++; $display("FAIL prio_mem_addr: got %h expected 12ab", mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (cpu_di !== 8'h21) begin errors++; $display("FAIL prio_cpu_di: got %h expected 21", cpu_di); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_refresh_inta();
    int req_seen = 0;
    @(negedge clk);
    cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h55;
    repeat (3) begin @(negedge clk); if (mem_req) req_seen++; end
    cpu_mreq_n = 1'b1; cpu_rfsh_n = 1'b1; cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
    repeat (3) begin @(negedge clk); if (mem_req) req_seen++; end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL rfsh_inta_req: got %0d expected 0", req_seen); end
    checks++; if (cpu_di !== 8'h21) begin errors++; $display("FAIL rfsh_inta_cpu_di: got %h expected 21", cpu_di); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL rfsh_inta_wait_n: got %b expected 1", cpu_wait_n); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_ack_at_limit();
    @(negedge clk);
    cpu_a = 16'h5000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; mem_rdata = 8'h3C;
    @(negedge clk);
    repeat (15) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL limit_req_held: got %b expected 1", mem_req); end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++; if (cpu_di !== 8'h3C) begin errors++; $display("FAIL limit_cpu_di: got %h expected 3c", cpu_di); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL limit_timeout: got %b expected 0", timeout_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL limit_req_drop: got %b expected 0", mem_req); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    @(negedge clk);
    cpu_a = 16'h4000; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; mem_rdata = 8'hAA;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      req_cycles++;
      @(negedge clk);
    end
    checks++; if (req_cycles != 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", req_cycles); end
    checks++; if (cpu_di !== 8'hFF) begin errors++; $display("FAIL to_cpu_di: got %h expected ff", cpu_di); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL to_wait_n: got %b expected 1", cpu_wait_n); end
    bus_idle();
    repeat (3) @(negedge clk);
    cpu_a = 16'h4001; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; mem_rdata = 8'h99; mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cpu_di !== 8'h99) begin errors++; $display("FAIL to_next_cpu_di: got %h expected 99", cpu_di); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_req();
    int req_seen = 0;
    @(negedge clk);
    cpu_a = 16'h7777; cpu_do = 8'h6B; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL mid_rst_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL mid_rst_wdata: got %h expected 00", mem_wdata); end
    checks++; if (cpu_di !== 8'h00) begin errors++; $display("FAIL mid_rst_cpu_di: got %h expected 00", cpu_di); end
    checks++; if (cpu_wait_n !== 1'b1) begin errors++; $display("FAIL mid_rst_wait_n: got %b expected 1", cpu_wait_n); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_timeout: got %b expected 0", timeout_err); end
    bus_idle();
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hEE;
    repeat (3) begin @(negedge clk); if (mem_req) req_seen++; end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL late_ack_req: got %0d expected 0", req_seen); end
    checks++; if (cpu_di !== 8'h00) begin errors++; $display("FAIL late_ack_cpu_di: got %h expected 00", cpu_di); end
    mem_ack = 1'b0;
    reset = 1'b1;
    cpu_a = 16'h0042; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_edge_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 16'h0042) begin errors++; $display("FAIL first_edge_addr: got %h expected 0042", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 8'h5D;
    @(negedge clk);
    checks++; if (cpu_di !== 8'h5D) begin errors++; $display("FAIL first_edge_cpu_di: got %h expected 5d", cpu_di); end
    mem_ack = 1'b0; bus_idle();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io_read();
    test_priority();
    test_refresh_inta();
    test_ack_at_limit();
    test_timeout();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
